mdio_phy_slave: RTL and testbench

- Clause-22 MDIO responder, i.e. the PHY/target end of the MDC/MDIO management interface that our MDIO write master drives.
- Oversamples MDC on the system clock and decodes frames (preamble, ST, OP, PHYAD, REGAD, TA, DATA).
- Writes go to a host-side register port. Reads are answered by driving MDIO.
- Sits between the board MDIO pins (tri-state at top level) and the local register bank.

---
 rtl/mdio_phy_slave.sv | 278 +++++++++++++++++++++++++++
 tb/tb_mdio_phy_slave.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mdio_phy_slave.sv
// mdio_phy_slave
// Clause-22 MDIO target. MDC and MDIO are oversampled on clk; each rising
// edge of the synchronised MDC advances the frame decoder by one bit.
// Writes land on the host register port (reg_we strobe), reads raise a
// reg_re strobe and the returned word is shifted out on MDIO.
//
// Ports:
//   clk        system clock, at least 4x the MDC frequency
//   rst        asynchronous reset, active-high
//   mdc        management clock from the master
//   mdio_i     MDIO pin input
//   mdio_o     MDIO drive value (idles high)
//   mdio_oe    MDIO output enable, 1 = drive the pin
//   reg_addr   register address of the current frame
//   reg_wdata  write data, valid with reg_we
//   reg_we     one-clk write strobe
//   reg_re     one-clk read-request strobe
//   reg_rdata  read data, sampled the clk after reg_re
//   frame_err  one-clk pulse on a malformed frame
module mdio_phy_slave #(
    parameter logic [4:0] PHY_ADDR     = 5'b10000,
    parameter int         PREAMBLE_MIN = 32,
    parameter int         SYNC_STAGES  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mdc,
    input  logic        mdio_i,
    output logic        mdio_o,
    output logic        mdio_oe,
    output logic [4:0]  reg_addr,
    output logic [15:0] reg_wdata,
    output logic        reg_we,
    output logic        reg_re,
    input  logic [15:0] reg_rdata,
    output logic        frame_err
);

    localparam int            PW      = $clog2(PREAMBLE_MIN + 1);
    localparam logic [PW-1:0] PRE_MAX = PW'(PREAMBLE_MIN);
    localparam logic [PW-1:0] PRE_ONE = PW'(1);
    localparam logic [PW-1:0] PRE_ZERO = PW'(0);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_ST2    = 4'd1,
        S_OP1    = 4'd2,
        S_OP2    = 4'd3,
        S_PHYAD  = 4'd4,
        S_REGAD  = 4'd5,
        S_TA_W   = 4'd6,
        S_DATA_W = 4'd7,
        S_TA_R   = 4'd8,
        S_DATA_R = 4'd9
    } state_t;

    logic [SYNC_STAGES-1:0] mdc_sync_r;
    logic [SYNC_STAGES-1:0] mdio_sync_r;
    logic                   mdc_prev_r;
    logic                   bit_edge_s;
    logic                   mdio_bit_s;

    state_t        state_r,   state_s;
    logic [PW-1:0] pre_cnt_r, pre_cnt_s;
    logic [4:0]    bit_cnt_r, bit_cnt_s;
    logic          is_read_r, is_read_s;
    logic [4:0]    phyad_r,   phyad_s;
    logic [4:0]    regad_r,   regad_s;
    logic [15:0]   shift_r,   shift_s;
    logic [4:0]    addr_s;
    logic [15:0]   wdata_s;
    logic          we_s, re_s, err_s, mdo_s, oe_s;

    // Synchronise MDC/MDIO and keep the previous MDC level for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mdc_sync_r  <= {SYNC_STAGES{1'b0}};
            mdio_sync_r <= {SYNC_STAGES{1'b0}};
            mdc_prev_r  <= 1'b0;
        end else begin
            mdc_sync_r  <= {mdc_sync_r[SYNC_STAGES-2:0], mdc};
            mdio_sync_r <= {mdio_sync_r[SYNC_STAGES-2:0], mdio_i};
            mdc_prev_r  <= mdc_sync_r[SYNC_STAGES-1];
        end
    end

    assign bit_edge_s = mdc_sync_r[SYNC_STAGES-1] & ~mdc_prev_r;
    assign mdio_bit_s = mdio_sync_r[SYNC_STAGES-1];

    // Frame decoder state and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= S_IDLE;
            pre_cnt_r <= PRE_ZERO;
            bit_cnt_r <= 5'd0;
            is_read_r <= 1'b0;
            phyad_r   <= 5'd0;
            regad_r   <= 5'd0;
            shift_r   <= 16'h0000;
            reg_addr  <= 5'd0;
            reg_wdata <= 16'h0000;
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
            frame_err <= 1'b0;
            mdio_o    <= 1'b1;
            mdio_oe   <= 1'b0;
        end else begin
            state_r   <= state_s;
            pre_cnt_r <= pre_cnt_s;
            bit_cnt_r <= bit_cnt_s;
            is_read_r <= is_read_s;
            phyad_r   <= phyad_s;
            regad_r   <= regad_s;
            shift_r   <= shift_s;
            reg_addr  <= addr_s;
            reg_wdata <= wdata_s;
            reg_we    <= we_s;
            reg_re    <= re_s;
            frame_err <= err_s;
            mdio_o    <= mdo_s;
            mdio_oe   <= oe_s;
        end
    end

    // Next-state and output decode, advancing only on MDC bit edges
    always_comb begin
        state_s   = state_r;
        pre_cnt_s = pre_cnt_r;
        bit_cnt_s = bit_cnt_r;
        is_read_s = is_read_r;
        phyad_s   = phyad_r;
        regad_s   = regad_r;
        shift_s   = shift_r;
        addr_s    = reg_addr;
        wdata_s   = reg_wdata;
        we_s      = 1'b0;
        re_s      = 1'b0;
        err_s     = 1'b0;
        mdo_s     = mdio_o;
        oe_s      = mdio_oe;

        // reg_rdata is valid the clk after the read strobe; no bit edge can
        // fall in that cycle because clk runs at least 4x MDC.
        if (reg_re) begin
            shift_s = reg_rdata;
        end else begin
            shift_s = shift_r;
        end

        if (bit_edge_s) begin
            case (state_r)
                S_IDLE: begin
                    if (mdio_bit_s) begin
                        if (pre_cnt_r != PRE_MAX) begin
                            pre_cnt_s = pre_cnt_r + PRE_ONE;
                        end else begin
                            pre_cnt_s = pre_cnt_r;
                        end
                    end else if (pre_cnt_r == PRE_MAX) begin
                        // Counter is cleared on leaving IDLE so every return
                        // path finds it at zero.
                        state_s   = S_ST2;
                        pre_cnt_s = PRE_ZERO;
                    end else begin
                        pre_cnt_s = PRE_ZERO;
                    end
                end
                S_ST2: begin
                    if (mdio_bit_s) begin
                        state_s = S_OP1;
                    end else begin
                        state_s = S_IDLE;
                        err_s   = 1'b1;
                    end
                end
                S_OP1: begin
                    is_read_s = mdio_bit_s;
                    state_s   = S_OP2;
                end
                S_OP2: begin
                    // Valid opcodes are 01 and 10: the two bits must differ
                    if (mdio_bit_s != is_read_r) begin
                        state_s   = S_PHYAD;
                        bit_cnt_s = 5'd0;
                    end else begin
                        state_s = S_IDLE;
                        err_s   = 1'b1;
                    end
                end
                S_PHYAD: begin
                    phyad_s = {phyad_r[3:0], mdio_bit_s};
                    if (bit_cnt_r == 5'd4) begin
                        state_s   = S_REGAD;
                        bit_cnt_s = 5'd0;
                    end else begin
                        bit_cnt_s = bit_cnt_r + 5'd1;
                    end
                end
                S_REGAD: begin
                    regad_s = {regad_r[3:0], mdio_bit_s};
                    if (bit_cnt_r == 5'd4) begin
                        bit_cnt_s = 5'd0;
                        if (phyad_r == PHY_ADDR) begin
                            addr_s = {regad_r[3:0], mdio_bit_s};
                            if (is_read_r) begin
                                re_s    = 1'b1;
                                state_s = S_TA_R;
                            end else begin
                                state_s = S_TA_W;
                            end
                        end else begin
                            state_s = S_IDLE;
                        end
                    end else begin
                        bit_cnt_s = bit_cnt_r + 5'd1;
                    end
                end
                S_TA_W: begin
                    // First TA bit is parked in shift_r[0] and checked with the second
                    shift_s = {shift_r[14:0], mdio_bit_s};
                    if (bit_cnt_r == 5'd0) begin
                        bit_cnt_s = 5'd1;
                    end else if (shift_r[0] && !mdio_bit_s) begin
                        state_s   = S_DATA_W;
                        bit_cnt_s = 5'd0;
                    end else begin
                        state_s = S_IDLE;
                        err_s   = 1'b1;
                    end
                end
                S_DATA_W: begin
                    shift_s = {shift_r[14:0], mdio_bit_s};
                    if (bit_cnt_r == 5'd15) begin
                        wdata_s = {shift_r[14:0], mdio_bit_s};
                        we_s    = 1'b1;
                        state_s = S_IDLE;
                    end else begin
                        bit_cnt_s = bit_cnt_r + 5'd1;
                    end
                end
                S_TA_R: begin
                    if (bit_cnt_r == 5'd0) begin
                        oe_s      = 1'b1;
                        mdo_s     = 1'b0;
                        bit_cnt_s = 5'd1;
                    end else begin
                        mdo_s     = shift_r[15];
                        shift_s   = {shift_r[14:0], 1'b0};
                        bit_cnt_s = 5'd0;
                        state_s   = S_DATA_R;
                    end
                end
                S_DATA_R: begin
                    // Edges 1..15 present rdata[14:0]; edge 16 is where the
                    // master samples rdata[0], after which the pin is released.
                    if (bit_cnt_r == 5'd15) begin
                        oe_s    = 1'b0;
                        mdo_s   = 1'b1;
                        state_s = S_IDLE;
                    end else begin
                        mdo_s     = shift_r[15];
                        shift_s   = {shift_r[14:0], 1'b0};
                        bit_cnt_s = bit_cnt_r + 5'd1;
                    end
                end
                default: begin
                    state_s   = S_IDLE;
                    pre_cnt_s = PRE_ZERO;
                    oe_s      = 1'b0;
                    mdo_s     = 1'b1;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

endmodule

// File: tb/tb_mdio_phy_slave.sv
// tb_mdio_phy_slave
// Drives Clause-22 frames into mdio_phy_slave from a table of vectors, with
// an MDIO line model (slave drive, else master drive, else pull-up).
// Expected strobes go into a scoreboard queue when a frame is issued and are
// popped as the DUT raises reg_we / reg_re / frame_err. Read frames check the
// serialised data bit by bit as the master would sample it.
module tb_mdio_phy_slave;

    localparam logic [4:0] PHY = 5'b10000;
    localparam logic [1:0] EV_WE  = 2'd0;
    localparam logic [1:0] EV_RE  = 2'd1;
    localparam logic [1:0] EV_ERR = 2'd2;

    logic        clk;
    logic        rst;
    logic        mdc;
    logic        mdio_i;
    logic        mdio_o;
    logic        mdio_oe;
    logic [4:0]  reg_addr;
    logic [15:0] reg_wdata;
    logic        reg_we;
    logic        reg_re;
    logic [15:0] reg_rdata;
    logic        frame_err;

    logic master_oe;
    logic master_val;
    logic mdio_line;
    logic oe_seen;

    int n_checks;
    int n_fail;

    typedef struct {
        logic [1:0]  kind;
        logic [4:0]  addr;
        logic [15:0] data;
    } ev_t;

    typedef struct {
        int          pre_len;
        logic [1:0]  op;
        logic [4:0]  phy;
        logic [4:0]  regad;
        logic [1:0]  ta;
        logic [15:0] data;
        logic        exp_we;
        logic        exp_re;
        logic        exp_err;
    } vec_t;

    ev_t  sb[$];
    vec_t vecs[13];

    mdio_phy_slave #(
        .PHY_ADDR    (5'b10000),
        .PREAMBLE_MIN(32),
        .SYNC_STAGES (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .mdc      (mdc),
        .mdio_i   (mdio_i),
        .mdio_o   (mdio_o),
        .mdio_oe  (mdio_oe),
        .reg_addr (reg_addr),
        .reg_wdata(reg_wdata),
        .reg_we   (reg_we),
        .reg_re   (reg_re),
        .reg_rdata(reg_rdata),
        .frame_err(frame_err)
    );

    assign mdio_line = mdio_oe ? mdio_o : (master_oe ? master_val : 1'b1);
    assign mdio_i    = mdio_line;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic sb_pop(input logic [1:0] kind, input logic [4:0] addr, input logic [15:0] data);
        ev_t e;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_event: got kind %0d addr 0x%0h data 0x%0h, expected none",
                     kind, addr, data);
        end else begin
            e = sb.pop_front();
            check("event_kind", {30'd0, kind}, {30'd0, e.kind});
            if (kind != EV_ERR) check("event_addr", {27'd0, addr}, {27'd0, e.addr});
            if (kind == EV_WE)  check("event_wdata", {16'd0, data}, {16'd0, e.data});
        end
    endtask

    // Scoreboard monitor: compare every strobe the DUT raises
    always @(negedge clk) begin
        if (!rst) begin
            if (reg_we && reg_re) check("we_re_exclusive", 32'd1, 32'd0);
            if (reg_we)    sb_pop(EV_WE, reg_addr, reg_wdata);
            if (reg_re)    sb_pop(EV_RE, reg_addr, 16'h0000);
            if (frame_err) sb_pop(EV_ERR, 5'd0, 16'h0000);
        end
    end

    // Note any cycle in which the slave drives the pin
    always @(negedge clk) begin
        if (mdio_oe) oe_seen = 1'b1;
    end

    // One MDC period: master sets the line while MDC is low, the pin is
    // sampled just before the rising edge (as a master would), then MDC high.
    task automatic send_bit(input logic b, input logic rel, output logic s_oe, output logic s_line);
        mdc        = 1'b0;
        master_oe  = !rel;
        master_val = b;
        #38;
        s_oe   = mdio_oe;
        s_line = mdio_line;
        #2;
        mdc = 1'b1;
        #40;
    endtask

    task automatic send_header(input int pre_len, input logic [1:0] op,
                               input logic [4:0] phy, input logic [4:0] regad);
        logic so, sl;
        send_bit(1'b0, 1'b0, so, sl);
        for (int i = 0; i < pre_len; i++) send_bit(1'b1, 1'b0, so, sl);
        send_bit(1'b0, 1'b0, so, sl);
        send_bit(1'b1, 1'b0, so, sl);
        send_bit(op[1], 1'b0, so, sl);
        send_bit(op[0], 1'b0, so, sl);
        for (int i = 4; i >= 0; i--) send_bit(phy[i], 1'b0, so, sl);
        for (int i = 4; i >= 0; i--) send_bit(regad[i], 1'b0, so, sl);
    endtask

    task automatic send_frame(input vec_t v);
        logic s_oe, s_line;
        int   driven;
        ev_t  e;
        reg_rdata = v.data;
        if (v.exp_we)  begin e.kind = EV_WE;  e.addr = v.regad; e.data = v.data;   sb.push_back(e); end
        if (v.exp_re)  begin e.kind = EV_RE;  e.addr = v.regad; e.data = 16'h0000; sb.push_back(e); end
        if (v.exp_err) begin e.kind = EV_ERR; e.addr = 5'd0;    e.data = 16'h0000; sb.push_back(e); end
        oe_seen = 1'b0;
        send_header(v.pre_len, v.op, v.phy, v.regad);
        if (v.op == 2'b10) begin
            driven = 0;
            // j=0 TA bit 1, j=1 TA bit 2, j=2..17 data sampled MSB first, j=18 after release
            for (int j = 0; j < 19; j++) begin
                send_bit(1'b1, 1'b1, s_oe, s_line);
                if (v.exp_re) begin
                    if (s_oe) driven++;
                    if (j == 0 || j == 18) begin
                        check($sformatf("rd_oe_released_%0d", j), {31'd0, s_oe}, 32'd0);
                    end else if (j == 1) begin
                        check("rd_ta_oe", {31'd0, s_oe}, 32'd1);
                        check("rd_ta_zero", {31'd0, s_line}, 32'd0);
                    end else begin
                        check($sformatf("rd_oe_bit%0d", 17 - j), {31'd0, s_oe}, 32'd1);
                        check($sformatf("rd_data_bit%0d", 17 - j), {31'd0, s_line}, {31'd0, v.data[17 - j]});
                    end
                end
            end
            if (v.exp_re) check("rd_driven_periods", driven, 32'd17);
        end else begin
            send_bit(v.ta[1], 1'b0, s_oe, s_line);
            send_bit(v.ta[0], 1'b0, s_oe, s_line);
            for (int i = 15; i >= 0; i--) send_bit(v.data[i], 1'b0, s_oe, s_line);
        end
        master_oe = 1'b1;
        master_val = 1'b1;
        repeat (12) @(negedge clk);
        check("sb_drained", sb.size(), 32'd0);
        if (!v.exp_re) check("oe_quiet", {31'd0, oe_seen}, 32'd0);
        sb.delete();
    endtask

    initial begin
        logic so, sl;
        ev_t  e;
        vec_t wv;
        n_checks   = 0;
        n_fail     = 0;
        rst        = 1'b1;
        mdc        = 1'b0;
        master_oe  = 1'b1;
        master_val = 1'b1;
        reg_rdata  = 16'h0000;
        oe_seen    = 1'b0;

        //            pre  op     phy       regad     ta     data     we    re    err
        vecs[0]  = '{32, 2'b01, PHY,      5'b10000, 2'b10, 16'h0060, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{32, 2'b10, PHY,      5'b00001, 2'b10, 16'h8140, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{32, 2'b01, 5'b00001, 5'b00011, 2'b10, 16'h1234, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{32, 2'b01, PHY,      5'b00101, 2'b10, 16'hABCD, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{31, 2'b01, PHY,      5'b00110, 2'b10, 16'h5A5A, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{32, 2'b01, PHY,      5'b00110, 2'b10, 16'h5A5A, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{32, 2'b11, PHY,      5'b00010, 2'b10, 16'h1111, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{32, 2'b01, PHY,      5'b00010, 2'b11, 16'h2222, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{32, 2'b10, PHY,      5'b11111, 2'b10, 16'hFFFF, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{32, 2'b01, PHY,      5'b11111, 2'b10, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{40, 2'b01, PHY,      5'b00000, 2'b10, 16'h0000, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{32, 2'b00, PHY,      5'b00100, 2'b10, 16'h3333, 1'b0, 1'b0, 1'b1};
        vecs[12] = '{32, 2'b10, 5'b00011, 5'b00111, 2'b10, 16'h4444, 1'b0, 1'b0, 1'b0};

        #25;
        check("rst_mdio_o",    {31'd0, mdio_o},    32'd1);
        check("rst_mdio_oe",   {31'd0, mdio_oe},   32'd0);
        check("rst_reg_addr",  {27'd0, reg_addr},  32'd0);
        check("rst_reg_wdata", {16'd0, reg_wdata}, 32'd0);
        check("rst_reg_we",    {31'd0, reg_we},    32'd0);
        check("rst_reg_re",    {31'd0, reg_re},    32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        #5;
        rst = 1'b0;

        for (int k = 0; k < 13; k++) send_frame(vecs[k]);

        // Reset in the middle of a read's data phase
        e.kind = EV_RE; e.addr = 5'd3; e.data = 16'h0000;
        sb.push_back(e);
        reg_rdata = 16'hC3A5;
        oe_seen   = 1'b0;
        send_header(32, 2'b10, PHY, 5'd3);
        for (int j = 0; j < 10; j++) send_bit(1'b1, 1'b1, so, sl);
        check("midrd_driving", {31'd0, mdio_oe}, 32'd1);
        rst = 1'b1;
        #1;
        check("midrd_rst_oe",   {31'd0, mdio_oe}, 32'd0);
        check("midrd_rst_o",    {31'd0, mdio_o},  32'd1);
        check("midrd_rst_addr", {27'd0, reg_addr}, 32'd0);
        #19;
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("midrd_sb_drained", sb.size(), 32'd0);
        sb.delete();

        wv = '{32, 2'b01, PHY, 5'b01010, 2'b10, 16'h9E37, 1'b1, 1'b0, 1'b0};
        send_frame(wv);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
